err_comp_acc: RTL and testbench

ERR_COMP_ACC -- requirements
Module: err_comp_acc

---
 rtl/err_comp_acc.sv | 145 ++++++++++++++
 tb/tb_err_comp_acc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/err_comp_acc.sv
// rtl/err_comp_acc.sv - rounding-error compensation accumulator for dot-product windows
module err_comp_acc #(
    parameter int N_TERMS = 16,
    parameter int ACC_W   = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             rounded_err,
    input  logic                    in_last,
    input  logic [ACC_W-1:0]        mac_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        err_acc,
    output logic [ACC_W-1:0]        corrected_sum,
    output logic [8:0]              term_cnt,
    output logic                    sat_flag,
    output logic                    align_err
);

    typedef enum logic {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [8:0]       N_TERMS_C = 9'(N_TERMS);
    localparam logic [ACC_W-1:0] MAX_VAL   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_VAL   = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [8:0]       cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             align_q, align_d;
    logic [ACC_W-1:0] err_acc_q, err_acc_d;
    logic [ACC_W-1:0] corr_q, corr_d;
    logic [8:0]       term_cnt_q, term_cnt_d;
    logic             sat_flag_q, sat_flag_d;
    logic             align_err_q, align_err_d;

    logic [ACC_W-1:0] err_ext;
    logic [ACC_W:0]   beat_wide;
    logic             beat_ovf;
    logic [ACC_W-1:0] beat_sum;
    logic [ACC_W:0]   corr_wide;
    logic             corr_ovf;
    logic [ACC_W-1:0] corr_sum;
    logic [8:0]       cnt_inc;
    logic             closing;
    logic             beat_align;

    // Datapath: one extra bit catches overflow of each add; clip to the signed range.
    always_comb begin
        err_ext    = {{(ACC_W-16){rounded_err[15]}}, rounded_err};
        beat_wide  = {sum_q[ACC_W-1], sum_q} + {err_ext[ACC_W-1], err_ext};
        beat_ovf   = beat_wide[ACC_W] ^ beat_wide[ACC_W-1];
        beat_sum   = beat_ovf ? (beat_wide[ACC_W] ? MIN_VAL : MAX_VAL)
                              : beat_wide[ACC_W-1:0];
        corr_wide  = {mac_sum[ACC_W-1], mac_sum} + {beat_sum[ACC_W-1], beat_sum};
        corr_ovf   = corr_wide[ACC_W] ^ corr_wide[ACC_W-1];
        corr_sum   = corr_ovf ? (corr_wide[ACC_W] ? MIN_VAL : MAX_VAL)
                              : corr_wide[ACC_W-1:0];
        cnt_inc    = cnt_q + 9'd1;
        closing    = in_last || (cnt_inc == N_TERMS_C);
        beat_align = |rounded_err[1:0];
    end

    // Next-state: accumulate in ACC, publish on the closing beat, clear on drain.
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        align_d     = align_q;
        err_acc_d   = err_acc_q;
        corr_d      = corr_q;
        term_cnt_d  = term_cnt_q;
        sat_flag_d  = sat_flag_q;
        align_err_d = align_err_q;
        if (state_q == S_ACC) begin
            if (in_valid) begin
                sum_d   = beat_sum;
                cnt_d   = cnt_inc;
                sat_d   = sat_q | beat_ovf;
                align_d = align_q | beat_align;
                if (closing) begin
                    err_acc_d   = beat_sum;
                    corr_d      = corr_sum;
                    term_cnt_d  = cnt_inc;
                    sat_flag_d  = sat_q | beat_ovf | corr_ovf;
                    align_err_d = align_q | beat_align;
                    state_d     = S_HOLD;
                end
            end
        end else begin
            if (out_ready) begin
                state_d = S_ACC;
                sum_d   = '0;
                cnt_d   = '0;
                sat_d   = 1'b0;
                align_d = 1'b0;
            end
        end
    end

    // State and result registers; reset discards any partial window or held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            sum_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            align_q     <= 1'b0;
            err_acc_q   <= '0;
            corr_q      <= '0;
            term_cnt_q  <= '0;
            sat_flag_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            align_q     <= align_d;
            err_acc_q   <= err_acc_d;
            corr_q      <= corr_d;
            term_cnt_q  <= term_cnt_d;
            sat_flag_q  <= sat_flag_d;
            align_err_q <= align_err_d;
        end
    end

    // Handshakes follow the state flop directly.
    always_comb begin
        in_ready      = (state_q == S_ACC);
        out_valid     = (state_q == S_HOLD);
        err_acc       = err_acc_q;
        corrected_sum = corr_q;
        term_cnt      = term_cnt_q;
        sat_flag      = sat_flag_q;
        align_err     = align_err_q;
    end

endmodule

// File: tb/tb_err_comp_acc.sv
// tb/tb_err_comp_acc.sv - self-checking bench for err_comp_acc
module tb_err_comp_acc;

    localparam int N_TERMS = 8;
    localparam int ACC_W   = 18;
    localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
    localparam longint MINV = -MAXV - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      rounded_err = '0;
    logic             in_last = 1'b0;
    logic [ACC_W-1:0] mac_sum = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] err_acc;
    logic [ACC_W-1:0] corrected_sum;
    logic [8:0]       term_cnt;
    logic             sat_flag;
    logic             align_err;

    int n_cmp = 0;
    int n_fail = 0;

    err_comp_acc #(.N_TERMS(N_TERMS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rounded_err(rounded_err), .in_last(in_last), .mac_sum(mac_sum),
        .out_valid(out_valid), .out_ready(out_ready), .err_acc(err_acc),
        .corrected_sum(corrected_sum), .term_cnt(term_cnt),
        .sat_flag(sat_flag), .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: keeps the window's beats and evaluates the result when it closes.
    int     beats[$];
    bit     m_hold;
    longint m_err, m_corr;
    int     m_cnt;
    bit     m_sat, m_align;

    task automatic model_reset();
        beats.delete();
        m_hold = 0; m_err = 0; m_corr = 0; m_cnt = 0; m_sat = 0; m_align = 0;
    endtask

    task automatic model_close(input longint mac);
        longint s;
        bit     sat, al;
        s = 0; sat = 0; al = 0;
        foreach (beats[i]) begin
            s = s + beats[i];
            if (s > MAXV) begin s = MAXV; sat = 1; end
            if (s < MINV) begin s = MINV; sat = 1; end
            if ((beats[i] % 4) != 0) al = 1;
        end
        m_err = s;
        m_corr = mac + s;
        if (m_corr > MAXV) begin m_corr = MAXV; sat = 1; end
        if (m_corr < MINV) begin m_corr = MINV; sat = 1; end
        m_cnt = beats.size();
        m_sat = sat;
        m_align = al;
        m_hold = 1;
        beats.delete();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else if (!m_hold) begin
                if (in_valid) begin
                    beats.push_back(int'($signed(rounded_err)));
                    if (in_last || beats.size() == N_TERMS)
                        model_close(longint'($signed(mac_sum)));
                end
            end else if (out_ready) begin
                m_hold = 0;
            end
        end
    end

    // Every cycle, away from the active edge, the DUT must match the model.
    always @(negedge clk) begin
        chk("in_ready", longint'(in_ready), longint'(!m_hold));
        chk("out_valid", longint'(out_valid), longint'(m_hold));
        chk("err_acc", longint'($signed(err_acc)), m_err);
        chk("corrected_sum", longint'($signed(corrected_sum)), m_corr);
        chk("term_cnt", longint'(term_cnt), longint'(m_cnt));
        chk("sat_flag", longint'(sat_flag), longint'(m_sat));
        chk("align_err", longint'(align_err), longint'(m_align));
    end

    task automatic beat(input int e, input bit last, input longint mac);
        int t;
        rounded_err = 16'(e);
        in_last = last;
        mac_sum = ACC_W'(mac);
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("beat_wait", longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("drain_wait", longint'(out_valid), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_drain", longint'(in_ready), 1);
    endtask

    task automatic lit(input string tag, input longint e_err, input longint e_corr,
                       input int e_cnt, input bit e_sat, input bit e_al);
        chk({tag, "_valid"}, longint'(out_valid), 1);
        chk({tag, "_err"}, longint'($signed(err_acc)), e_err);
        chk({tag, "_corr"}, longint'($signed(corrected_sum)), e_corr);
        chk({tag, "_cnt"}, longint'(term_cnt), longint'(e_cnt));
        chk({tag, "_sat"}, longint'(sat_flag), longint'(e_sat));
        chk({tag, "_align"}, longint'(align_err), longint'(e_al));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_err", longint'($signed(err_acc)), 0);
        chk("rst_cnt", longint'(term_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic window with in_last
        beat(-8, 0, 0); beat(12, 0, 0); beat(4, 0, 0); beat(-4, 1, 100);
        lit("w1", 4, 104, 4, 0, 0);
        // Stall in HOLD with input pending
        in_valid = 1'b1; rounded_err = 16'd999; in_last = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_in_ready", longint'(in_ready), 0);
            chk("hold_err", longint'($signed(err_acc)), 4);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("drained_in_ready", longint'(in_ready), 1);
        chk("retain_err", longint'($signed(err_acc)), 4);
        chk("retain_corr", longint'($signed(corrected_sum)), 104);

        beat(16, 0, 0); beat(8, 1, -50);
        lit("w2", 24, -26, 2, 0, 0);
        drain();

        for (int i = 0; i < N_TERMS; i++) beat(4, 0, 0);
        lit("w_full", 32, 32, 8, 0, 0);
        drain();

        for (int i = 0; i < 3; i++) beat(32764, 0, 0);
        beat(32764, 1, 131000);
        lit("w_corr_sat", 131056, 131071, 4, 1, 0);
        drain();

        for (int i = 0; i < 4; i++) beat(-32768, 0, 0);
        beat(-32768, 1, 0);
        lit("w_neg_sat", -131072, -131072, 5, 1, 0);
        drain();

        beat(5, 0, 0); beat(4, 1, 0);
        lit("w_align", 9, 9, 2, 0, 1);
        drain();
        beat(4, 1, 0);
        lit("w_noalign", 4, 4, 1, 0, 0);
        drain();

        beat(100, 0, 0); beat(200, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_err", longint'($signed(err_acc)), 0);
        chk("midrst_in_ready", longint'(in_ready), 1);
        chk("midrst_cnt", longint'(term_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        beat(7, 1, 0);
        lit("w_postrst", 7, 7, 1, 0, 1);
        drain();

        // Random traffic; the per-cycle compare process does the checking
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0)
                rounded_err = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7fff;
            else
                rounded_err = 16'($urandom_range(0, 65535));
            mac_sum   = ACC_W'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            rst_n     = ($urandom_range(0, 599) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
